// File: rtl/aes_spi_slave.sv
// aes_spi_slave: serial host front-end for an AES core.
// The host shifts in a frame (optional direction byte, message, key), the core
// is launched once, and the 128-bit result is shifted back out on sdo.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for load rising; done/sdo hold last outcome
// SHIFT_IN  | host shifting frame bits in on sck rising
// START     | one-clk core_start pulse, core inputs frozen
// BUSY      | waiting for core_done
// SHIFT_OUT | result shifted out on sck falling
module aes_spi_slave #(
    parameter int K   = 128,
    parameter int INV = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           sck,
    input  logic           sdi,
    input  logic           load,
    output logic           sdo,
    output logic           done,
    output logic           core_start,
    output logic           core_dir,
    output logic [127:0]   core_msg,
    output logic [K-1:0]   core_key,
    input  logic           core_done,
    input  logic [127:0]   core_result,
    output logic           len_err
);

    localparam int DW = (INV == 2) ? 8 : 0;
    localparam int N  = K + 128 + DW;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [2:0] {IDLE, SHIFT_IN, START, BUSY, SHIFT_OUT} state_t;

    state_t          state, state_nxt;
    logic [1:0]      sck_sync, sdi_sync, load_sync;
    logic            sck_prev, load_prev;
    logic            sck_rise, sck_fall, load_rise, load_fall;
    logic [N-1:0]    frame;
    logic [CW-1:0]   bit_cnt;
    logic [127:0]    out_reg;
    logic [6:0]      out_cnt;
    logic            dir_q, dir_calc;
    logic            frame_full;

    // Two-flop synchronizers plus one delay flop for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_sync  <= '0;
            sdi_sync  <= '0;
            load_sync <= '0;
            sck_prev  <= 1'b0;
            load_prev <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[0], sck};
            sdi_sync  <= {sdi_sync[0], sdi};
            load_sync <= {load_sync[0], load};
            sck_prev  <= sck_sync[1];
            load_prev <= load_sync[1];
        end
    end

    assign sck_rise   = sck_sync[1] & ~sck_prev;
    assign sck_fall   = ~sck_sync[1] & sck_prev;
    assign load_rise  = load_sync[1] & ~load_prev;
    assign load_fall  = ~load_sync[1] & load_prev;
    assign frame_full = (bit_cnt == CW'(N));

    // Direction selection; runtime mode treats any non-zero byte as decrypt.
    always_comb begin
        dir_calc = 1'b0;
        if (INV == 1)
            dir_calc = 1'b1;
        else if (INV == 2)
            dir_calc = |frame[N-1 -: 8];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; load edges in START/BUSY are deliberately ignored.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (load_rise) state_nxt = SHIFT_IN;
            SHIFT_IN:  if (load_fall) state_nxt = frame_full ? START : IDLE;
            START:     state_nxt = BUSY;
            BUSY:      if (core_done) state_nxt = SHIFT_OUT;
            SHIFT_OUT: begin
                if (load_rise)
                    state_nxt = SHIFT_IN;
                else if (sck_fall && out_cnt == 7'd127)
                    state_nxt = IDLE;
            end
            default:   state_nxt = IDLE;
        endcase
    end

    // Output decode for the single-cycle pulses.
    always_comb begin
        core_start = (state == START);
        len_err    = (state == SHIFT_IN) && load_fall && !frame_full;
    end

    // Datapath: frame capture, result capture and shift-out.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame   <= '0;
            bit_cnt <= '0;
            out_reg <= '0;
            out_cnt <= '0;
            done    <= 1'b0;
            dir_q   <= 1'b0;
        end else begin
            case (state)
                IDLE, SHIFT_OUT: begin
                    if (load_rise) begin
                        bit_cnt <= '0;
                        done    <= 1'b0;
                        out_reg <= '0;
                    end else if (state == SHIFT_OUT && sck_fall) begin
                        out_reg <= {out_reg[126:0], 1'b0};
                        out_cnt <= out_cnt + 7'd1;
                    end
                end
                SHIFT_IN: begin
                    if (sck_rise && !frame_full) begin
                        frame   <= {frame[N-2:0], sdi_sync[1]};
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                START: dir_q <= dir_calc;
                BUSY: begin
                    if (core_done) begin
                        out_reg <= core_result;
                        out_cnt <= '0;
                        done    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sdo      = out_reg[127];
    assign core_dir = dir_q;
    assign core_msg = frame[K+127:K];
    assign core_key = frame[K-1:0];

endmodule

// File: doc/aes_spi_slave.md
AES_SPI_SLAVE -- requirements
Module: aes_spi_slave

Interface
REQ-001 Parameter K, default 128, key width; legal values 128, 192, 256.
REQ-002 Parameter INV, default 2, direction mode: 0 = encrypt only, 1 = decrypt only, 2 = runtime select via direction byte.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 sck  in  1  host serial clock, asynchronous to clk.
REQ-006 sdi  in  1  host serial data in, MSB first.
REQ-007 load  in  1  high while the host shifts a frame in.
REQ-008 sdo  out  1  serial result out, MSB first.
REQ-009 done  out  1  result ready for shift-out.
REQ-010 core_start  out  1  one-clk pulse that launches the AES core.
REQ-011 core_dir  out  1  0 = encrypt, 1 = decrypt.
REQ-012 core_msg  out  128  input block to the core.
REQ-013 core_key  out  K  key to the core.
REQ-014 core_done  in  1  core result valid; level or pulse.
REQ-015 core_result  in  128  core output block.
REQ-016 len_err  out  1  one-clk pulse on a malformed frame.

Function
REQ-017 sck, sdi and load SHALL each pass through a 2-flop synchronizer; sck edges are detected on the synchronized copy.
REQ-018 Host timing: sck high and low phases SHALL each last at least 2 clk periods; sdi is stable across the sck rise.
REQ-019 Frame length N = K+128+8 when INV=2, otherwise K+128; bit order is direction byte (INV=2 only), then message, then key, each MSB first.
REQ-020 States: IDLE, SHIFT_IN, START, BUSY, SHIFT_OUT.
REQ-021 IDLE -> SHIFT_IN on synchronized load rising; bit counter cleared, done cleared.
REQ-022 SHIFT_IN: each synchronized sck rising shifts sdi into the frame register and increments the counter.
REQ-023 SHIFT_IN: the counter saturates at N; bits beyond N are discarded, not shifted.
REQ-024 SHIFT_IN -> START on load falling with count == N.
REQ-025 SHIFT_IN -> IDLE on load falling with count != N: len_err pulses, no core_start is issued, done stays 0.
REQ-026 START: core_start = 1 for exactly one clk, then -> BUSY.
REQ-027 core_msg, core_key and core_dir SHALL be driven from the frame register and held constant from START until the next load rising.
REQ-028 core_dir mapping: INV=0 gives 0; INV=1 gives 1; INV=2 gives 0 if the direction byte is 8'h00, else 1.
REQ-029 BUSY: on core_done = 1, capture core_result into the output shift register, set done = 1, sdo = result[127], then -> SHIFT_OUT.
REQ-030 SHIFT_OUT: each synchronized sck falling shifts the register left; sdo presents the next bit, so the host samples on sck rising.
REQ-031 SHIFT_OUT -> IDLE after the 128th sck falling; sdo = 0 and done stays 1 until the next load rising.
REQ-032 Load rising in SHIFT_OUT or IDLE SHALL abort any output and enter SHIFT_IN; load edges in START and BUSY are ignored.
REQ-033 sck edges outside SHIFT_IN and SHIFT_OUT SHALL be ignored.
REQ-034 core_done outside BUSY SHALL be ignored.

Reset
REQ-035 While reset = 1: state = IDLE, counters = 0, frame and output registers = 0, sdo = 0, done = 0, core_start = 0, len_err = 0, core_dir = 0.
REQ-036 Reset asserted mid-operation in any state SHALL abandon the frame; the next frame starts cleanly from load rising.
REQ-037 Synchronizer flops SHALL reset to 0.

Verification
REQ-038 K=128, INV=2, direction byte FF, message 3925841D02DC09FBDC118597196A0B32, key 2B7E151628AED2A6ABF7158809CF4F3C -> core_dir = 1, core_msg and core_key equal the shifted values, exactly one core_start; core model returns 3243F6A8885A308D313198A2E0370734 -> 128 bits read out equal it.
REQ-039 Same frame with direction byte 00 and message 3243F6A8885A308D313198A2E0370734 -> core_dir = 0; result 3925841D02DC09FBDC118597196A0B32 shifted out exactly.
REQ-040 K=256, INV=0, key 000102...1F, message 00112233445566778899AABBCCDDEEFF -> 384-bit frame accepted, core_dir = 0, result 8EA2B7CA516745BFEAFC49904B496089 shifted out.
REQ-041 Frame of N-1 bits, then N+5 bits -> first frame: len_err pulses once, no core_start; second frame: bits 1..N latched, extra bits ignored, normal start.
REQ-042 Reset pulsed during BUSY, then a full valid frame -> done = 0 after reset; second run completes correctly with one core_start.
REQ-043 load raised after 40 output bits -> SHIFT_OUT aborted, done = 0, new frame processed normally.
